noc_test_node: RTL and testbench



---
 rtl/noc_test_node.sv | 208 ++++++++++++++++++++
 tb/tb_noc_test_node.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_test_node.sv
// NoC traffic endpoint: injects NUM_PKTS packets toward (DEST_X_ID, DEST_Y_ID) and counts packets it receives.
// Optional content checking of received packets is enabled by defining NOC_TEST_NODE_CHECK_EN.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_test_node #(
    parameter int X_ID        = 0,
    parameter int Y_ID        = 0,
    parameter int DEST_X_ID   = 1,
    parameter int DEST_Y_ID   = 1,
    parameter int NUM_PKTS    = 4,
    parameter int PKT_LEN     = 4,
    parameter int START_DELAY = 4,
    parameter int GAP         = 2
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic                       receive_valid,
    output logic                       receive_ready,
    input  logic [`Noc_Data_Width-1:0] receive_flit,
    input  logic                       receive_is_header,
    input  logic                       receive_is_tail,
    output logic                       sender_valid,
    input  logic                       sender_ready,
    output logic [`Noc_Data_Width-1:0] sender_flit,
    output logic                       sender_is_header,
    output logic                       sender_is_tail,
    output logic [7:0]                 receive_num
);
    localparam int W = `Noc_Data_Width;
    localparam logic [3:0]  SRC_X     = 4'(X_ID);
    localparam logic [3:0]  SRC_Y     = 4'(Y_ID);
    localparam logic [3:0]  DST_X     = 4'(DEST_X_ID);
    localparam logic [3:0]  DST_Y     = 4'(DEST_Y_ID);
    localparam logic [15:0] LAST_K    = 16'(PKT_LEN - 1);
    localparam logic [7:0]  LAST_P    = 8'(NUM_PKTS - 1);
    localparam logic [31:0] START_CNT = 32'(START_DELAY);
    localparam logic [31:0] GAP_CNT   = 32'(GAP - 1);

    typedef enum logic [1:0] {S_WAIT, S_SEND, S_GAP, S_DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  pkt_idx, pkt_idx_n, load_pkt;
    logic [15:0] flit_idx, flit_idx_n;
    logic [31:0] cnt, cnt_n;
    logic        valid_n, hdr_n, tail_n, load_hdr;
    logic [W-1:0] flit_n;

    function automatic logic [W-1:0] make_flit(input logic [7:0] pn, input logic [15:0] kn);
        logic [W-1:0] f;
        f = '0;
        if (kn == 16'd0) f[23:0] = {pn, SRC_Y, SRC_X, DST_Y, DST_X};
        else             f[23:0] = {SRC_Y, SRC_X, pn, kn[7:0]};
        return f;
    endfunction

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state            <= S_WAIT;
            pkt_idx          <= '0;
            flit_idx         <= '0;
            cnt              <= '0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
        end else begin
            state            <= state_n;
            pkt_idx          <= pkt_idx_n;
            flit_idx         <= flit_idx_n;
            cnt              <= cnt_n;
            sender_valid     <= valid_n;
            sender_flit      <= flit_n;
            sender_is_header <= hdr_n;
            sender_is_tail   <= tail_n;
        end
    end

    // Outputs are registered: every branch computes the flit to present in the next cycle.
    always_comb begin
        state_n    = state;
        pkt_idx_n  = pkt_idx;
        flit_idx_n = flit_idx;
        cnt_n      = cnt;
        valid_n    = sender_valid;
        flit_n     = sender_flit;
        hdr_n      = sender_is_header;
        tail_n     = sender_is_tail;
        load_hdr   = 1'b0;
        load_pkt   = pkt_idx;
        case (state)
            S_WAIT: begin
                if (cnt == START_CNT) load_hdr = 1'b1;
                else                  cnt_n = cnt + 32'd1;
            end
            S_SEND: begin
                if (sender_valid && sender_ready) begin
                    if (flit_idx == LAST_K) begin
                        valid_n = 1'b0;
                        flit_n  = '0;
                        hdr_n   = 1'b0;
                        tail_n  = 1'b0;
                        if (pkt_idx == LAST_P) begin
                            state_n = S_DONE;
                        end else if (GAP == 0) begin
                            load_hdr = 1'b1;
                            load_pkt = pkt_idx + 8'd1;
                        end else begin
                            state_n = S_GAP;
                            cnt_n   = '0;
                        end
                    end else begin
                        flit_idx_n = flit_idx + 16'd1;
                        flit_n     = make_flit(pkt_idx, flit_idx + 16'd1);
                        hdr_n      = 1'b0;
                        tail_n     = (flit_idx + 16'd1 == LAST_K);
                    end
                end
            end
            S_GAP: begin
                if (cnt == GAP_CNT) begin
                    load_hdr = 1'b1;
                    load_pkt = pkt_idx + 8'd1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: ;
        endcase
        if (load_hdr) begin
            state_n    = S_SEND;
            pkt_idx_n  = load_pkt;
            flit_idx_n = '0;
            cnt_n      = '0;
            valid_n    = 1'b1;
            flit_n     = make_flit(load_pkt, 16'd0);
            hdr_n      = 1'b1;
            tail_n     = (LAST_K == 16'd0);
        end
    end

    logic accept, close_ok, pkt_ok, pkt_open;
    assign accept   = receive_valid & receive_ready;
    assign close_ok = receive_is_tail & (receive_is_header | pkt_open);

`ifdef NOC_TEST_NODE_CHECK_EN
    logic [3:0]   chk_sx, chk_sy;
    logic [7:0]   chk_p, chk_k;
    logic         chk_bad, hdr_bad, body_bad;
    logic [W-1:0] body_exp;

    always_comb begin
        body_exp       = '0;
        body_exp[23:0] = {chk_sy, chk_sx, chk_p, chk_k};
        hdr_bad        = (receive_flit[7:0] != {SRC_Y, SRC_X});
        body_bad       = (receive_flit != body_exp);
        pkt_ok         = receive_is_header ? !hdr_bad : !(chk_bad || body_bad);
    end

    // Source and packet number come from the header; body flits are checked against them.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            chk_sx  <= '0;
            chk_sy  <= '0;
            chk_p   <= '0;
            chk_k   <= '0;
            chk_bad <= 1'b0;
        end else if (accept) begin
            if (receive_is_header) begin
                chk_sx  <= receive_flit[11:8];
                chk_sy  <= receive_flit[15:12];
                chk_p   <= receive_flit[23:16];
                chk_k   <= 8'd1;
                chk_bad <= hdr_bad;
            end else if (pkt_open) begin
                chk_k   <= chk_k + 8'd1;
                chk_bad <= chk_bad | body_bad;
            end
`ifndef SYNTHESIS
            if (close_ok && !pkt_ok)
                $display("noc_test_node(%0d,%0d): error: corrupted packet dropped", X_ID, Y_ID);
`endif
        end
    end
`else
    logic unused_flit;
    assign unused_flit = ^receive_flit;
    assign pkt_ok      = 1'b1;
`endif

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            receive_ready <= 1'b0;
            pkt_open      <= 1'b0;
            receive_num   <= '0;
        end else begin
            receive_ready <= 1'b1;
            if (accept) begin
                if (receive_is_header)    pkt_open <= ~receive_is_tail;
                else if (receive_is_tail) pkt_open <= 1'b0;
                if (close_ok && pkt_ok && receive_num != 8'hFF)
                    receive_num <= receive_num + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_test_node.sv
// Bench for noc_test_node: loopback traffic against a spec-level flit model, stalls, direct receive
// stimulus, mid-packet reset and count saturation on a second 255-packet instance.
`timescale 1ns/1ps
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module tb_noc_test_node;
    localparam int W           = `Noc_Data_Width;
    localparam int NUM_PKTS    = 4;
    localparam int PKT_LEN     = 4;
    localparam int START_DELAY = 4;
    localparam int GAP         = 2;
    localparam int BIG_PKTS    = 255;
    localparam int BIG_LEN     = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, big_rst_n;

    // shared direct-drive receive stimulus
    logic         ext_valid, ext_hdr, ext_tail;
    logic [W-1:0] ext_flit;

    // main node (0,0) -> (0,0)
    logic         loop_en, s_valid, s_ready, s_hdr, s_tail, r_ready;
    logic [W-1:0] s_flit, r_flit;
    logic         r_valid, r_hdr, r_tail;
    logic [7:0]   r_num;
    assign r_valid = loop_en ? (s_valid & s_ready) : ext_valid;
    assign r_flit  = loop_en ? s_flit : ext_flit;
    assign r_hdr   = loop_en ? s_hdr  : ext_hdr;
    assign r_tail  = loop_en ? s_tail : ext_tail;

    noc_test_node #(.X_ID(0), .Y_ID(0), .DEST_X_ID(0), .DEST_Y_ID(0), .NUM_PKTS(NUM_PKTS),
                    .PKT_LEN(PKT_LEN), .START_DELAY(START_DELAY), .GAP(GAP)) dut (
        .noc_clk(clk), .noc_rst_n(rst_n),
        .receive_valid(r_valid), .receive_ready(r_ready), .receive_flit(r_flit),
        .receive_is_header(r_hdr), .receive_is_tail(r_tail),
        .sender_valid(s_valid), .sender_ready(s_ready), .sender_flit(s_flit),
        .sender_is_header(s_hdr), .sender_is_tail(s_tail), .receive_num(r_num));

    // saturation node (3,5) -> (3,5)
    logic         big_loop, big_sv, big_sr, big_sh, big_st, big_rr;
    logic [W-1:0] big_sf, big_rf;
    logic         big_rv, big_rh, big_rt;
    logic [7:0]   big_num;
    assign big_rv = big_loop ? (big_sv & big_sr) : ext_valid;
    assign big_rf = big_loop ? big_sf : ext_flit;
    assign big_rh = big_loop ? big_sh : ext_hdr;
    assign big_rt = big_loop ? big_st : ext_tail;

    noc_test_node #(.X_ID(3), .Y_ID(5), .DEST_X_ID(3), .DEST_Y_ID(5), .NUM_PKTS(BIG_PKTS),
                    .PKT_LEN(BIG_LEN), .START_DELAY(0), .GAP(1)) dut_big (
        .noc_clk(clk), .noc_rst_n(big_rst_n),
        .receive_valid(big_rv), .receive_ready(big_rr), .receive_flit(big_rf),
        .receive_is_header(big_rh), .receive_is_tail(big_rt),
        .sender_valid(big_sv), .sender_ready(big_sr), .sender_flit(big_sf),
        .sender_is_header(big_sh), .sender_is_tail(big_st), .receive_num(big_num));

    // scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   mark_q[$];
    int  cyc, hs_idx, exp_rx, idle, ready_mode;
    bit  first_seen, in_gap;
    logic pv, pr, ph, pt;
    logic [W-1:0] pf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pattern(input int sx, input int sy, input int dx, input int dy,
                                             input int p, input int k);
        longint v;
        if (k == 0) v = dx + dy * 16 + sx * 256 + sy * 4096 + p * 65536;
        else        v = k + p * 256 + sx * 65536 + sy * 1048576;
        return W'(v);
    endfunction

    task automatic check_reset_outputs();
        check("rst_sender_valid", s_valid, 0);
        check("rst_sender_flit", s_flit, 0);
        check("rst_markers", {s_hdr, s_tail}, 0);
        check("rst_receive_ready", r_ready, 0);
        check("rst_receive_num", r_num, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        mark_q.delete();
        for (int p = 0; p < NUM_PKTS; p++)
            for (int k = 0; k < PKT_LEN; k++) begin
                exp_q.push_back(pattern(0, 0, 0, 0, p, k));
                mark_q.push_back({k == 0, k == PKT_LEN - 1});
            end
        cyc = 0; hs_idx = 0; exp_rx = 0; idle = 0;
        first_seen = 0; in_gap = 0;
        pv = 0; pr = 0; ph = 0; pt = 0; pf = '0;
        s_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // driver + monitor for one loopback cycle on the main node
    task automatic tick();
        logic [W-1:0] ef;
        logic [1:0]   em;
        @(negedge clk);
        cyc++;
        if (cyc == 1) check("ready_after_reset", r_ready, 1);
        if (pv && pr) begin
            check("handshake_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                ef = exp_q.pop_front();
                em = mark_q.pop_front();
                check("flit", pf, ef);
                check("markers", {ph, pt}, em);
                if (hs_idx == 0)  check("header0_value", pf, 64'h0);
                if (hs_idx == 11) check("tail_p2_value", pf, 64'h203);
                hs_idx++;
                if (em[0]) begin
                    exp_rx = (exp_rx >= 255) ? 255 : exp_rx + 1;
                    if (exp_q.size() != 0) begin in_gap = 1; idle = 0; end
                end
            end
        end else if (pv) begin
            check("hold_valid", s_valid, 1);
            check("hold_flit", s_flit, pf);
            check("hold_markers", {s_hdr, s_tail}, {ph, pt});
        end
        if (s_valid && !first_seen) begin
            first_seen = 1;
            check("first_header_cycle", cyc, START_DELAY + 1);
        end
        if (in_gap) begin
            if (s_valid) begin check("gap_cycles", idle, GAP); in_gap = 0; end
            else idle++;
        end
        check("receive_num", r_num, exp_rx);
        case (ready_mode)
            0:       s_ready = 1'($urandom_range(0, 1));
            1:       s_ready = 1'b0;
            default: s_ready = 1'b1;
        endcase
        pv = s_valid; pr = s_ready; pf = s_flit; ph = s_hdr; pt = s_tail;
    endtask

    task automatic run_loopback(input bit do_hold);
        int guard, hold_left;
        bit held;
        guard = 0; hold_left = 0; held = 0;
        while ((exp_q.size() != 0 || in_gap) && guard < 2000) begin
            if (do_hold && !held && s_valid && !s_hdr && !s_tail && hs_idx >= 4) begin
                held = 1;
                hold_left = 10;
            end
            ready_mode = (hold_left > 0) ? 1 : 0;
            if (hold_left > 0) hold_left--;
            tick();
            guard++;
        end
        check("loopback_finished", guard < 2000, 1);
        ready_mode = 2;
        repeat (3) tick();
        check("final_receive_num", r_num, NUM_PKTS);
    endtask

    task automatic rx_flit(input bit h, input bit t, input logic [W-1:0] f);
        ext_valid = 1'b1; ext_hdr = h; ext_tail = t; ext_flit = f;
        @(negedge clk);
        ext_valid = 1'b0; ext_hdr = 1'b0; ext_tail = 1'b0;
    endtask

    initial begin
        int guard, tails, bp, bk, base, rp, rsx, rsy;
        logic bpv, bpr, bph, bpt;
        logic [W-1:0] bpf;

        rst_n = 1'b1; big_rst_n = 1'b1;
        loop_en = 1'b1; big_loop = 1'b1; big_sr = 1'b0; s_ready = 1'b0; ready_mode = 0;
        ext_valid = 1'b0; ext_hdr = 1'b0; ext_tail = 1'b0; ext_flit = '0;
        #1;
        big_rst_n = 1'b0;

        // loopback with random ready and a 10-cycle stall mid-packet
        do_reset();
        run_loopback(1);

        // direct receive stimulus: strays, foreign-dest packet, restarted packet
        loop_en = 1'b0;
        base = NUM_PKTS;
        rx_flit(0, 0, W'($urandom));
        rx_flit(0, 1, W'($urandom));
        check("stray_dropped", r_num, base);
        check("ready_steady", r_ready, 1);
        rx_flit(1, 0, pattern(0, 0, 1, 1, 0, 0));
        rx_flit(0, 0, pattern(0, 0, 1, 1, 0, 1));
        rx_flit(0, 0, pattern(0, 0, 1, 1, 0, 2));
        rx_flit(0, 1, pattern(0, 0, 1, 1, 0, 3));
`ifdef NOC_TEST_NODE_CHECK_EN
        check("foreign_dest_packet", r_num, base);
`else
        base++;
        check("foreign_dest_packet", r_num, base);
`endif
        rp = $urandom_range(0, 255); rsx = $urandom_range(0, 15); rsy = $urandom_range(0, 15);
        rx_flit(1, 0, pattern(rsx, rsy, 0, 0, rp, 0));
        rx_flit(0, 0, pattern(rsx, rsy, 0, 0, rp, 1));
        rp = $urandom_range(0, 255);
        rx_flit(1, 0, pattern(rsx, rsy, 0, 0, rp, 0));
        check("restart_not_counted_yet", r_num, base);
        rx_flit(0, 0, pattern(rsx, rsy, 0, 0, rp, 1));
        rx_flit(0, 0, pattern(rsx, rsy, 0, 0, rp, 2));
        rx_flit(0, 1, pattern(rsx, rsy, 0, 0, rp, 3));
        base++;
        check("restarted_packet", r_num, base);
        rx_flit(0, 1, W'($urandom));
        check("tail_without_open", r_num, base);

        // asynchronous reset in the middle of a packet, then a full clean run
        loop_en = 1'b1;
        do_reset();
        guard = 0;
        ready_mode = 0;
        while (!(s_valid && !s_hdr && hs_idx >= 5) && guard < 500) begin
            tick();
            guard++;
        end
        check("mid_packet_reached", guard < 500, 1);
        #2;
        do_reset();
        run_loopback(0);

        // 255 packets with random ready, then saturation
        @(negedge clk);
        big_rst_n = 1'b1;
        tails = 0; bp = 0; bk = 0; guard = 0;
        bpv = 0; bpr = 0; bph = 0; bpt = 0; bpf = '0;
        while (guard < 6000 && (tails < BIG_PKTS || big_sv)) begin
            @(negedge clk);
            guard++;
            if (bpv && bpr) begin
                check("big_flit", bpf, pattern(3, 5, 3, 5, bp, bk));
                check("big_markers", {bph, bpt}, {bk == 0, bk == BIG_LEN - 1});
                if (bk == BIG_LEN - 1) begin bk = 0; bp++; tails++; end
                else bk++;
            end
            check("big_receive_num", big_num, (tails > 255) ? 255 : tails);
            big_sr = 1'($urandom_range(0, 1));
            bpv = big_sv; bpr = big_sr; bpf = big_sf; bph = big_sh; bpt = big_st;
        end
        check("big_tails", tails, BIG_PKTS);
        check("big_num_full", big_num, 255);
        repeat (5) @(negedge clk);
        check("big_sender_done", big_sv, 0);
        big_loop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_flit(1, 0, pattern(3, 5, 3, 5, i, 0));
            rx_flit(0, 1, pattern(3, 5, 3, 5, i, 1));
            check("big_saturated", big_num, 255);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
